// File: rtl/bot_port_pkg.sv
// bot_port_pkg: KCPSM6 port addresses (low 5 bits of port_id) and digit-code width.
package bot_port_pkg;
    localparam int DIG_W = 5;
    localparam logic [4:0] PA_PBTNS   = 5'h00;
    localparam logic [4:0] PA_SLSWTCH = 5'h01;
    localparam logic [4:0] PA_SHSWTCH = 5'h02;
    localparam logic [4:0] PA_LEDS_LO = 5'h01;
    localparam logic [4:0] PA_LEDS_HI = 5'h02;
    localparam logic [4:0] PA_DIG3    = 5'h03;
    localparam logic [4:0] PA_DIG2    = 5'h04;
    localparam logic [4:0] PA_DIG1    = 5'h05;
    localparam logic [4:0] PA_DIG0    = 5'h06;
    localparam logic [4:0] PA_DP_LO   = 5'h07;
    localparam logic [4:0] PA_MOTCTL  = 5'h09;
    localparam logic [4:0] PA_DIG7    = 5'h0B;
    localparam logic [4:0] PA_DIG6    = 5'h0C;
    localparam logic [4:0] PA_DIG5    = 5'h0D;
    localparam logic [4:0] PA_DIG4    = 5'h0E;
    localparam logic [4:0] PA_DP_HI   = 5'h0F;
    localparam logic [4:0] PA_LOCX    = 5'h0A;
    localparam logic [4:0] PA_LOCY    = 5'h0B;
    localparam logic [4:0] PA_BOTINFO = 5'h0C;
    localparam logic [4:0] PA_SENSORS = 5'h0D;
    localparam logic [4:0] PA_LMDIST  = 5'h0E;
    localparam logic [4:0] PA_RMDIST  = 5'h0F;
    localparam logic [4:0] PA_OVRUN   = 5'h10;
endpackage

// File: rtl/bot_intr_ctl.sv
// bot_intr_ctl: interrupt flag, saturating overrun counter and shadow-capture enable.
module bot_intr_ctl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       upd_i,
    input  logic       ack_i,
    input  logic       clr_i,
    output logic       irq_o,
    output logic [7:0] ovr_o,
    output logic       cap_o
);
    logic       flag_q, flag_d;
    logic [7:0] ovr_q, ovr_d;
    logic       inc;

    // a new update outranks a simultaneous acknowledge
    always_comb begin
        inc    = upd_i & flag_q;
        flag_d = upd_i | (flag_q & ~ack_i);
        ovr_d  = clr_i ? {7'd0, inc} : (inc && ovr_q != 8'hFF) ? ovr_q + 8'd1 : ovr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
            ovr_q  <= 8'h00;
        end else begin
            flag_q <= flag_d;
            ovr_q  <= ovr_d;
        end
    end

    assign irq_o = flag_q;
    assign ovr_o = ovr_q;
    assign cap_o = upd_i;
endmodule

// File: rtl/bot_port_responder.sv
// bot_port_responder: KCPSM6 port-bus peripheral serving bot, button and switch registers
// and holding CPU-written motor control, display digits, decimal points and LEDs.
module bot_port_responder
    import bot_port_pkg::*;
#(
    parameter logic [7:0] RESET_MOTCTL = 8'h00,
    parameter bit         SNAPSHOT     = 1'b1
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic [7:0]       port_id,
    input  logic [7:0]       io_data_in,
    output logic [7:0]       io_data_out,
    input  logic             read_strobe,
    input  logic             write_strobe,
    input  logic             k_write_strobe,
    output logic             interrupt,
    input  logic             interrupt_ack,
    input  logic [5:0]       dbbtns,
    input  logic [15:0]      Switches,
    input  logic [7:0]       locx,
    input  logic [7:0]       locy,
    input  logic [7:0]       botinfo,
    input  logic [7:0]       sensors,
    input  logic [7:0]       lmdist,
    input  logic [7:0]       rmdist,
    input  logic             upd_sysregs,
    output logic [7:0]       MotCtl,
    output logic [DIG_W-1:0] dig0,
    output logic [DIG_W-1:0] dig1,
    output logic [DIG_W-1:0] dig2,
    output logic [DIG_W-1:0] dig3,
    output logic [DIG_W-1:0] dig4,
    output logic [DIG_W-1:0] dig5,
    output logic [DIG_W-1:0] dig6,
    output logic [DIG_W-1:0] dig7,
    output logic [7:0]       dp,
    output logic [15:0]      LEDS
);
    logic [7:0]       motctl_q, motctl_d, dp_q, dp_d, rd_q, rd_d, ovr_cnt;
    logic [15:0]      leds_q, leds_d;
    logic [DIG_W-1:0] dig_q [8];
    logic [DIG_W-1:0] dig_d [8];
    logic [4:0]       waddr;
    logic             wen, cap_en;
    logic [5:0][7:0]  bot_live, bot_rd;
    logic             unused;

    assign unused   = &{1'b0, port_id[7:5]};
    assign bot_live = {rmdist, lmdist, sensors, botinfo, locy, locx};

    bot_intr_ctl u_intr (
        .clk   (sysclk),
        .rst_n (sysreset),
        .upd_i (upd_sysregs),
        .ack_i (interrupt_ack),
        .clr_i (read_strobe && port_id[4:0] == PA_OVRUN),
        .irq_o (interrupt),
        .ovr_o (ovr_cnt),
        .cap_o (cap_en)
    );

    generate
        if (SNAPSHOT) begin : g_snap
            logic [5:0][7:0] shadow_q;
            always_ff @(posedge sysclk or negedge sysreset) begin
                if (!sysreset) shadow_q <= '0;
                else if (cap_en) shadow_q <= bot_live;
            end
            assign bot_rd = shadow_q;
        end else begin : g_live
            assign bot_rd = bot_live;
        end
    endgenerate

    // read data follows port_id every cycle; the CPU samples it on its own schedule
    always_comb begin
        rd_d = 8'h00;
        case (port_id[4:0])
            PA_PBTNS:   rd_d = {2'b00, dbbtns};
            PA_SLSWTCH: rd_d = Switches[7:0];
            PA_SHSWTCH: rd_d = Switches[15:8];
            PA_LOCX:    rd_d = bot_rd[0];
            PA_LOCY:    rd_d = bot_rd[1];
            PA_BOTINFO: rd_d = bot_rd[2];
            PA_SENSORS: rd_d = bot_rd[3];
            PA_LMDIST:  rd_d = bot_rd[4];
            PA_RMDIST:  rd_d = bot_rd[5];
            PA_OVRUN:   rd_d = ovr_cnt;
            default:    ;
        endcase
    end

    // constant-port writes only see port_id[3:0]
    always_comb begin
        wen      = write_strobe | k_write_strobe;
        waddr    = write_strobe ? port_id[4:0] : {1'b0, port_id[3:0]};
        motctl_d = motctl_q;
        leds_d   = leds_q;
        dp_d     = dp_q;
        dig_d    = dig_q;
        if (wen) begin
            case (waddr)
                PA_LEDS_LO: leds_d[7:0]  = io_data_in;
                PA_LEDS_HI: leds_d[15:8] = io_data_in;
                PA_DIG3:    dig_d[3]     = io_data_in[DIG_W-1:0];
                PA_DIG2:    dig_d[2]     = io_data_in[DIG_W-1:0];
                PA_DIG1:    dig_d[1]     = io_data_in[DIG_W-1:0];
                PA_DIG0:    dig_d[0]     = io_data_in[DIG_W-1:0];
                PA_DP_LO:   dp_d[3:0]    = io_data_in[3:0];
                PA_MOTCTL:  motctl_d     = io_data_in;
                PA_DIG7:    dig_d[7]     = io_data_in[DIG_W-1:0];
                PA_DIG6:    dig_d[6]     = io_data_in[DIG_W-1:0];
                PA_DIG5:    dig_d[5]     = io_data_in[DIG_W-1:0];
                PA_DIG4:    dig_d[4]     = io_data_in[DIG_W-1:0];
                PA_DP_HI:   dp_d[7:4]    = io_data_in[3:0];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            motctl_q <= RESET_MOTCTL;
            leds_q   <= 16'h0000;
            dp_q     <= 8'h00;
            rd_q     <= 8'h00;
            for (int i = 0; i < 8; i++) dig_q[i] <= '0;
        end else begin
            motctl_q <= motctl_d;
            leds_q   <= leds_d;
            dp_q     <= dp_d;
            rd_q     <= rd_d;
            dig_q    <= dig_d;
        end
    end

    assign io_data_out = rd_q;
    assign MotCtl      = motctl_q;
    assign LEDS        = leds_q;
    assign dp          = dp_q;
    assign {dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0} =
        {dig_q[7], dig_q[6], dig_q[5], dig_q[4], dig_q[3], dig_q[2], dig_q[1], dig_q[0]};
endmodule
